// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// one-cycle Data_Valid / Framing_Error pulses and a held output byte.
module uart_rx #(
  parameter int CLKS_PER_BIT = 108,
  parameter int HALF_BIT     = 54
) (
  input  logic       CLOCK_50,
  input  logic       Reset_n,
  input  logic       Serial_Data,
  output logic [7:0] Output_Data,
  output logic       Data_Valid,
  output logic       Framing_Error,
  output logic       Busy
);

  localparam int TW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] BIT_END  = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] HALF_END = TW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic          prev_q, prev_d;
  logic [1:0]    arm_q, arm_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          rx;
  logic          fall;

  assign rx = sync2_q;

  // The synchronizer's reset value is not a real line observation, so edge
  // detection is held off until both sync flops and prev_q carry true samples.
  // This keeps a line held low across reset release from starting a frame.
  assign fall = (arm_q == 2'd3) && prev_q && !rx;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    prev_d    = rx;
    arm_d     = (arm_q == 2'd3) ? arm_q : arm_q + 2'd1;

    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_END) begin
          timer_d   = '0;
          bit_cnt_d = '0;
          state_d   = rx ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      DATA: begin
        if (timer_q == BIT_END) begin
          shift_d[bit_cnt_q] = rx;
          timer_d            = '0;
          bit_cnt_d          = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      STOP: begin
        if (timer_q == BIT_END) begin
          timer_d = '0;
          // Returning to IDLE at the stop mid-point leaves half a bit to catch
          // a start edge that follows the stop bit directly.
          if (rx) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      prev_q    <= 1'b1;
      arm_q     <= 2'd0;
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync1_q   <= Serial_Data;
      sync2_q   <= sync1_q;
      prev_q    <= prev_d;
      arm_q     <= arm_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign Output_Data   = data_q;
  assign Data_Valid    = valid_q;
  assign Framing_Error = ferr_q;
  assign Busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames
// compared against a frame-level model (good stop -> byte out, bad stop -> error).
module tb_uart_rx;

  localparam int CPB = 108;

  logic       CLOCK_50 = 1'b0;
  logic       Reset_n;
  logic       Serial_Data;
  logic [7:0] Output_Data;
  logic       Data_Valid;
  logic       Framing_Error;
  logic       Busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got[$];
  int         fe_cnt      = 0;
  int         overlap_cnt = 0;
  int         long_cnt    = 0;
  logic       dv_prev     = 1'b0;
  logic       fe_prev     = 1'b0;

  uart_rx #(.CLKS_PER_BIT(CPB), .HALF_BIT(CPB / 2)) dut (
    .CLOCK_50      (CLOCK_50),
    .Reset_n       (Reset_n),
    .Serial_Data   (Serial_Data),
    .Output_Data   (Output_Data),
    .Data_Valid    (Data_Valid),
    .Framing_Error (Framing_Error),
    .Busy          (Busy)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Output monitor: records every received byte and pulse anomaly.
  always @(negedge CLOCK_50) begin
    if (Data_Valid) got.push_back(Output_Data);
    if (Framing_Error) fe_cnt <= fe_cnt + 1;
    if (Data_Valid && Framing_Error) overlap_cnt <= overlap_cnt + 1;
    if ((Data_Valid && dv_prev) || (Framing_Error && fe_prev)) long_cnt <= long_cnt + 1;
    dv_prev <= Data_Valid;
    fe_prev <= Framing_Error;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
    Serial_Data = 1'b0;
    wait_cyc(cpb);
    for (int i = 0; i < 8; i++) begin
      Serial_Data = b[i];
      wait_cyc(cpb);
    end
    Serial_Data = stop;
    wait_cyc(cpb);
  endtask

  task automatic test_reset();
    Reset_n     = 1'b0;
    Serial_Data = 1'b0;
    wait_cyc(3);
    n_cmp++; if (Output_Data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", Output_Data); end
    n_cmp++; if (Data_Valid !== 1'b0) begin n_bad++; $display("FAIL reset_dv: got %b want 0", Data_Valid); end
    n_cmp++; if (Framing_Error !== 1'b0) begin n_bad++; $display("FAIL reset_fe: got %b want 0", Framing_Error); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    Reset_n = 1'b1;
    wait_cyc(300);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL low_at_reset_busy: got %b want 0", Busy); end
    n_cmp++; if (got.size() !== 0) begin n_bad++; $display("FAIL low_at_reset_dv: got %0d pulses want 0", got.size()); end
    Serial_Data = 1'b1;
    wait_cyc(20);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", Busy); end
  endtask

  task automatic test_single();
    int g0;
    int f0;
    g0 = got.size();
    f0 = fe_cnt;
    send_byte(8'hA5, CPB, 1'b1);
    wait_cyc(20);
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL a5_pulses: got %0d want 1", got.size() - g0); end
    else begin
      n_cmp++; if (got[g0] !== 8'hA5) begin n_bad++; $display("FAIL a5_byte: got %h want a5", got[g0]); end
    end
    n_cmp++; if (Output_Data !== 8'hA5) begin n_bad++; $display("FAIL a5_hold: got %h want a5", Output_Data); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL a5_busy: got %b want 0", Busy); end
    n_cmp++; if (fe_cnt - f0 !== 0) begin n_bad++; $display("FAIL a5_fe: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_false_start();
    logic [7:0] prev;
    int g0;
    prev = Output_Data;
    g0   = got.size();
    Serial_Data = 1'b0;
    wait_cyc(20);
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL fs_busy_low: got %b want 1", Busy); end
    Serial_Data = 1'b1;
    wait_cyc(80);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL fs_busy_after: got %b want 0", Busy); end
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL fs_dv: got %0d want 0", got.size() - g0); end
    n_cmp++; if (Output_Data !== prev) begin n_bad++; $display("FAIL fs_data: got %h want %h", Output_Data, prev); end
  endtask

  task automatic test_framing();
    logic [7:0] prev;
    int g0;
    int f0;
    prev = Output_Data;
    g0   = got.size();
    f0   = fe_cnt;
    send_byte(8'h3C, CPB, 1'b0);
    wait_cyc(2000);
    n_cmp++; if (fe_cnt - f0 !== 1) begin n_bad++; $display("FAIL fe_pulses: got %0d want 1", fe_cnt - f0); end
    n_cmp++; if (Busy !== 1'b1) begin n_bad++; $display("FAIL fe_busy_break: got %b want 1", Busy); end
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL fe_dv: got %0d want 0", got.size() - g0); end
    n_cmp++; if (Output_Data !== prev) begin n_bad++; $display("FAIL fe_data: got %h want %h", Output_Data, prev); end
    Serial_Data = 1'b1;
    wait_cyc(10);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL fe_busy_release: got %b want 0", Busy); end
    n_cmp++; if (fe_cnt - f0 !== 1) begin n_bad++; $display("FAIL fe_no_more: got %0d want 1", fe_cnt - f0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b[3];
    int g0;
    exp_b = '{8'h00, 8'hFF, 8'h81};
    g0 = got.size();
    for (int i = 0; i < 3; i++) send_byte(exp_b[i], CPB, 1'b1);
    wait_cyc(20);
    n_cmp++; if (got.size() - g0 !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", got.size() - g0); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++; if (got[g0 + i] !== exp_b[i]) begin n_bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, got[g0 + i], exp_b[i]); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int g0;
    int f0;
    b  = 8'h55;
    g0 = got.size();
    f0 = fe_cnt;
    Serial_Data = 1'b0;
    wait_cyc(CPB);
    for (int i = 0; i < 4; i++) begin
      Serial_Data = b[i];
      wait_cyc(CPB);
    end
    Serial_Data = b[4];
    wait_cyc(CPB / 2);
    Reset_n = 1'b0;
    wait_cyc(3);
    Reset_n     = 1'b1;
    Serial_Data = 1'b1;
    wait_cyc(20);
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
    n_cmp++; if (Output_Data !== 8'h00) begin n_bad++; $display("FAIL rstmid_data: got %h want 00", Output_Data); end
    n_cmp++; if (got.size() - g0 !== 0) begin n_bad++; $display("FAIL rstmid_dv: got %0d want 0", got.size() - g0); end
    send_byte(8'h12, CPB, 1'b1);
    wait_cyc(20);
    n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL rstmid_12_count: got %0d want 1", got.size() - g0); end
    n_cmp++; if (Output_Data !== 8'h12) begin n_bad++; $display("FAIL rstmid_12_data: got %h want 12", Output_Data); end
    n_cmp++; if (fe_cnt - f0 !== 0) begin n_bad++; $display("FAIL rstmid_fe: got %0d want 0", fe_cnt - f0); end
  endtask

  task automatic test_baud_tolerance();
    int rates[2];
    int g0;
    rates = '{106, 110};
    for (int r = 0; r < 2; r++) begin
      g0 = got.size();
      send_byte(8'h96, rates[r], 1'b1);
      wait_cyc(20);
      n_cmp++; if (got.size() - g0 !== 1) begin n_bad++; $display("FAIL baud%0d_count: got %0d want 1", rates[r], got.size() - g0); end
      n_cmp++; if (Output_Data !== 8'h96) begin n_bad++; $display("FAIL baud%0d_data: got %h want 96", rates[r], Output_Data); end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    int cpb;
    int exp_fe;
    int g0;
    int f0;
    bit good;
    exp_fe = 0;
    g0 = got.size();
    f0 = fe_cnt;
    for (int k = 0; k < 16; k++) begin
      b    = 8'($urandom_range(0, 255));
      cpb  = $urandom_range(106, 110);
      good = ($urandom_range(0, 4) != 0);
      send_byte(b, cpb, good);
      // Frame-level model: a high stop bit delivers the byte, a low one only flags an error.
      if (good) exp_q.push_back(b);
      else exp_fe++;
      Serial_Data = 1'b1;
      wait_cyc($urandom_range(2, 25));
    end
    wait_cyc(20);
    n_cmp++; if (got.size() - g0 !== exp_q.size()) begin n_bad++; $display("FAIL rand_count: got %0d want %0d", got.size() - g0, exp_q.size()); end
    else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        n_cmp++; if (got[g0 + i] !== exp_q[i]) begin n_bad++; $display("FAIL rand_byte%0d: got %h want %h", i, got[g0 + i], exp_q[i]); end
      end
    end
    n_cmp++; if (fe_cnt - f0 !== exp_fe) begin n_bad++; $display("FAIL rand_fe: got %0d want %0d", fe_cnt - f0, exp_fe); end
    n_cmp++; if (Busy !== 1'b0) begin n_bad++; $display("FAIL rand_busy: got %b want 0", Busy); end
  endtask

  task automatic test_pulse_rules();
    n_cmp++; if (overlap_cnt !== 0) begin n_bad++; $display("FAIL pulse_overlap: got %0d want 0", overlap_cnt); end
    n_cmp++; if (long_cnt !== 0) begin n_bad++; $display("FAIL pulse_width: got %0d long pulses want 0", long_cnt); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_false_start();
    test_framing();
    test_back_to_back();
    test_reset_mid();
    test_baud_tolerance();
    test_random();
    test_pulse_rules();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
